regfile_wb_arbiter: RTL and testbench

Shares the single general-purpose register file write port between several writeback sources: the main pipeline WB stage, the multi-cycle mul/div unit and the coprocessor/load-return path. The block arbitrates valid/ready requests, either round-robin or with requester 0 holding fixed priority, and registers the winner into a one-entry output stage. That stage drives the register file write port and doubles as a forwarding source. It sits between the WB-stage sources and the register file, with the hazard unit observing its outputs.

---
 rtl/regfile_wb_arbiter_pkg.sv | 28 ++
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter_pick.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Default widths describe the standard 32-bit, 32-entry register file.
package wb_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  // Pointer/index width for n requesters; never below one bit.
  function automatic int ptr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

  // Round-robin pointer after a transfer from winner.
  // Under prio0, a requester-0 win keeps the pointer and slot 0 is never a start point.
  function automatic int rr_next(input int ptr, input int winner, input bit prio0, input int n);
    int nxt;
    if (prio0 && winner == 0) return ptr;
    nxt = (winner + 1) % n;
    if (prio0 && nxt == 0) nxt = 1;
    return nxt;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus plus register-file write port of the arbiter.
// master = requesters / register-file side, slave = arbiter.
interface regfile_wb_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  localparam int PTR_W = ptr_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            pending;
  logic                          wr_stall;
  logic                          wr_en;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [PTR_W-1:0]              last_grant;

  modport master (
    output req_valid, req_addr, req_data, wr_stall,
    input  req_ready, pending, wr_en, wr_addr, wr_data, last_grant
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_stall,
    output req_ready, pending, wr_en, wr_addr, wr_data, last_grant
  );

endinterface

// File: rtl/regfile_wb_arbiter_pick.sv
// Combinational round-robin picker with optional fixed top priority for bit 0.
// Winner is the valid request at the smallest rotated distance from start_i.
module rr_priority_pick
  import wb_arb_pkg::*;
#(
  parameter int  N = 3,
  localparam int W = ptr_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  input  logic         prio0_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int best_d;
  int d;
  int pick;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    best_d = N;
    d      = 0;
    pick   = 0;
    any_o  = 1'b0;
    if (prio0_i && req_i[0]) begin
      any_o = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        d = (i + N - int'(start_i)) % N;
        if (req_i[i] && !(prio0_i && i == 0) && d < best_d) begin
          best_d = d;
          pick   = i;
          any_o  = 1'b1;
        end
      end
    end
    idx_o   = W'(pick);
    grant_o = any_o ? (N'(1) << pick) : '0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback sources onto the single register-file write port and
// registers the winner into a one-entry output stage that stalls in place.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int PRIO0      = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int               PTR_W     = ptr_w(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_RESET = (PRIO0 != 0) ? PTR_W'(1) : '0;

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      last_grant_q, last_grant_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [NUM_REQ-1:0]    pick_req;
  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      win_idx;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A stall (or reset) hides every request so nothing is granted or acknowledged.
  assign pick_req = bus.req_valid & {NUM_REQ{~(bus.wr_stall | reset)}};

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (pick_req),
    .start_i (rr_ptr_q),
    .prio0_i (PRIO0 != 0),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (xfer)
  );

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    last_grant_d = last_grant_q;
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (!bus.wr_stall) begin
      wr_en_d = 1'b0;
      if (xfer) begin
        // Address 0 is acknowledged and captured but never written.
        wr_en_d      = (addr_arr[win_idx] != '0);
        wr_addr_d    = addr_arr[win_idx];
        wr_data_d    = data_arr[win_idx];
        last_grant_d = win_idx;
        rr_ptr_d     = PTR_W'(rr_next(int'(rr_ptr_q), int'(win_idx), PRIO0 != 0, NUM_REQ));
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= PTR_RESET;
      last_grant_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.pending    = bus.req_valid & ~grant;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: one round-robin and one prio0 instance,
// with a scoreboard of expected register-file writes checked by a monitor.
module tb_regfile_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_rr ();
  regfile_wb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_p0 ();

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIO0(0)) dut_rr (
    .clock (clock),
    .reset (reset),
    .bus   (if_rr.slave)
  );

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIO0(1)) dut_p0 (
    .clock (clock),
    .reset (reset),
    .bus   (if_p0.slave)
  );

  wb_req_t q_rr[$];
  wb_req_t q_p0[$];
  wb_req_t e_rr, e_p0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic lane_rr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if_rr.req_addr[i*AW +: AW] = a;
    if_rr.req_data[i*DW +: DW] = d;
  endtask

  task automatic lane_p0(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if_p0.req_addr[i*AW +: AW] = a;
    if_p0.req_data[i*DW +: DW] = d;
  endtask

  task automatic exp_rr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_req_t e;
    e.addr = a;
    e.data = d;
    q_rr.push_back(e);
  endtask

  task automatic exp_p0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_req_t e;
    e.addr = a;
    e.data = d;
    q_p0.push_back(e);
  endtask

  // Waits for the sampling edge and checks the p0 instance's grant and pending vectors.
  task automatic grant_p0(input string tag, input logic [NR-1:0] rdy);
    @(negedge clock);
    check({tag, "_ready"}, if_p0.req_ready, rdy);
    check({tag, "_pending"}, if_p0.pending, if_p0.req_valid & ~rdy);
  endtask

  // A write commits at the edge following a cycle with wr_en=1 and no stall.
  always @(negedge clock) begin
    if (!reset) begin
      if (if_rr.wr_en && !if_rr.wr_stall) begin
        if (q_rr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rr_write: unexpected write addr=0x%0h data=0x%0h, expected none", if_rr.wr_addr, if_rr.wr_data);
        end else begin
          e_rr = q_rr.pop_front();
          check("rr_wr_addr", if_rr.wr_addr, e_rr.addr);
          check("rr_wr_data", if_rr.wr_data, e_rr.data);
        end
      end
      if (if_p0.wr_en && !if_p0.wr_stall) begin
        if (q_p0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL p0_write: unexpected write addr=0x%0h data=0x%0h, expected none", if_p0.wr_addr, if_p0.wr_data);
        end else begin
          e_p0 = q_p0.pop_front();
          check("p0_wr_addr", if_p0.wr_addr, e_p0.addr);
          check("p0_wr_data", if_p0.wr_data, e_p0.data);
        end
      end
    end
  end

  logic [NR-1:0] rot_rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [AW-1:0] rot_addr [4] = '{5'd1, 5'd2, 5'd3, 5'd1};
  logic [DW-1:0] rot_data [4] = '{32'h101, 32'h102, 32'h103, 32'h101};
  logic [1:0]    rot_lg [4] = '{2'd0, 2'd0, 2'd1, 2'd2};

  initial begin
    if_rr.req_valid = '0; if_rr.req_addr = '0; if_rr.req_data = '0; if_rr.wr_stall = 1'b0;
    if_p0.req_valid = '0; if_p0.req_addr = '0; if_p0.req_data = '0; if_p0.wr_stall = 1'b0;

    // Reset state, including no grant while reset is held with requests present.
    #2;
    check("rst_rr_wr_en", if_rr.wr_en, 1'b0);
    check("rst_p0_wr_en", if_p0.wr_en, 1'b0);
    check("rst_p0_wr_addr", if_p0.wr_addr, '0);
    check("rst_p0_wr_data", if_p0.wr_data, '0);
    check("rst_p0_last_grant", if_p0.last_grant, '0);
    if_rr.req_valid = 3'b111;
    if_p0.req_valid = 3'b111;
    #1;
    check("rst_rr_ready", if_rr.req_ready, 3'b000);
    check("rst_p0_ready", if_p0.req_ready, 3'b000);
    if_rr.req_valid = '0;
    if_p0.req_valid = '0;
    step();
    reset = 1'b0;

    // Pure round-robin: all three valid, grants rotate 0,1,2,0.
    lane_rr(0, 5'd1, 32'h101);
    lane_rr(1, 5'd2, 32'h102);
    lane_rr(2, 5'd3, 32'h103);
    if_rr.req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_rr(rot_addr[k], rot_data[k]);
      @(negedge clock);
      check("rr_rot_ready", if_rr.req_ready, rot_rdy[k]);
      check("rr_rot_pending", if_rr.pending, 3'b111 & ~rot_rdy[k]);
      if (k > 0) check("rr_rot_last_grant", if_rr.last_grant, rot_lg[k]);
      step();
    end
    if_rr.req_valid = '0;

    // Fixed priority: requester 0 always wins while valid.
    lane_p0(0, 5'd4, 32'h204);
    lane_p0(1, 5'd5, 32'h205);
    lane_p0(2, 5'd6, 32'h206);
    if_p0.req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      exp_p0(5'd4, 32'h204);
      grant_p0("p0_hold", 3'b001);
      step();
    end
    if_p0.req_valid = 3'b110;
    exp_p0(5'd5, 32'h205);
    grant_p0("p0_drop_r1", 3'b010);
    step();
    if_p0.req_valid = 3'b100;
    exp_p0(5'd6, 32'h206);
    grant_p0("p0_drop_r2", 3'b100);
    step();

    // Address 0: acknowledged, data captured, no write, pointer still advances to 2.
    lane_p0(1, 5'd0, 32'hDEAD_BEEF);
    if_p0.req_valid = 3'b010;
    grant_p0("a0_grant", 3'b010);
    step();
    lane_p0(1, 5'h0A, 32'hA0A0);
    lane_p0(2, 5'h0B, 32'hB0B0);
    if_p0.req_valid = 3'b110;
    exp_p0(5'h0B, 32'hB0B0);
    grant_p0("a0_ptr2", 3'b100);
    check("a0_wr_en", if_p0.wr_en, 1'b0);
    check("a0_wr_data", if_p0.wr_data, 32'hDEAD_BEEF);
    check("a0_last_grant", if_p0.last_grant, 2'd1);
    step();
    if_p0.req_valid = 3'b010;
    exp_p0(5'h0A, 32'hA0A0);
    grant_p0("a0_next", 3'b010);
    step();

    // Stall holds the presented write and blocks all grants.
    lane_p0(1, 5'd5, 32'h1234);
    if_p0.req_valid = 3'b010;
    exp_p0(5'd5, 32'h1234);
    grant_p0("st_xfer", 3'b010);
    step();
    lane_p0(1, 5'h0C, 32'h5555);
    lane_p0(2, 5'h0D, 32'h6666);
    if_p0.req_valid = 3'b110;
    if_p0.wr_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      grant_p0("st_hold", 3'b000);
      check("st_wr_en", if_p0.wr_en, 1'b1);
      check("st_wr_addr", if_p0.wr_addr, 5'd5);
      check("st_wr_data", if_p0.wr_data, 32'h1234);
      step();
    end
    if_p0.wr_stall = 1'b0;
    exp_p0(5'h0D, 32'h6666);
    grant_p0("st_release", 3'b100);
    step();
    if_p0.req_valid = 3'b010;
    exp_p0(5'h0C, 32'h5555);
    grant_p0("st_after", 3'b010);
    step();

    // Back-to-back writes from requester 2.
    for (int k = 0; k < 3; k++) begin
      lane_p0(2, AW'(7 + k), 32'h907 + k);
      if_p0.req_valid = 3'b100;
      exp_p0(AW'(7 + k), 32'h907 + k);
      grant_p0("b2b", 3'b100);
      if (k > 0) begin
        check("b2b_wr_en", if_p0.wr_en, 1'b1);
        check("b2b_wr_addr", if_p0.wr_addr, AW'(6 + k));
      end
      step();
    end
    if_p0.req_valid = '0;
    @(negedge clock);
    check("b2b_last_addr", if_p0.wr_addr, 5'd9);
    step();
    @(negedge clock);
    check("idle_wr_en", if_p0.wr_en, 1'b0);
    check("idle_wr_addr_hold", if_p0.wr_addr, 5'd9);
    check("idle_wr_data_hold", if_p0.wr_data, 32'h909);
    step();

    // Reset during a stalled write drops it without a clock edge.
    lane_p0(1, 5'd3, 32'h77);
    if_p0.req_valid = 3'b010;
    exp_p0(5'd3, 32'h77);
    grant_p0("rs_xfer", 3'b010);
    step();
    if_p0.req_valid = '0;
    if_p0.wr_stall = 1'b1;
    @(negedge clock);
    check("rs_held_wr_en", if_p0.wr_en, 1'b1);
    #2;
    reset = 1'b1;
    void'(q_p0.pop_back());
    #1;
    check("rs_async_wr_en", if_p0.wr_en, 1'b0);
    check("rs_async_wr_addr", if_p0.wr_addr, '0);
    if_p0.wr_stall = 1'b0;
    step();
    reset = 1'b0;
    step();
    @(negedge clock);
    check("rs_after_wr_en", if_p0.wr_en, 1'b0);
    step();

    check("rr_queue_drained", q_rr.size(), 0);
    check("p0_queue_drained", q_p0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
